disp_arbiter: RTL and testbench
===============================

// Module: disp_arbiter
// PURPOSE
//   Shares the 8-digit, active-low 7-segment display between three frame requesters
//   (e.g. indicator animation, status, message).
//   Fixed-priority arbitration with a minimum hold time, a blank gap between owners,
//   and the digit-scan multiplexer that drives disp_an / disp_o.
//   Sits between the frame generators and the board display pins.
// PARAMETERS
//   SCAN_DIV   131072  clk cycles per digit slot (must be >= 2)
//   HOLD_CYC   2**24   min cycles an owner keeps the display before preemption (>= 1)
//   BLANK_CYC  65536   blank-gap cycles between owners (>= 1)
// PORTS
//   clk       in   1   system clock
//   rst_n     in   1   synchronous active-low reset
//   req       in   3   request per source; bit 0 = highest priority
//   frame0    in   56  source 0 frame; digit k = frame0[7k+6:7k], digit 7 at MSB, seg active-low
//   frame1    in   56  source 1 frame, same layout
//   frame2    in   56  source 2 frame, same layout
//   grant     out  3   one-hot current owner; 0 when no owner
//   disp_an   out  8   digit enable, active-low, one-hot-zero
//   disp_o    out  7   segments of selected digit, active-low
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge):
//   - state=IDLE, grant=0, sel=0, scan_c=0, hold_c=0, blank_c=0.
//   - disp_an=8'hFF, disp_o=7'h7F.
//   Scan:
//   - scan_c counts 0..SCAN_DIV-1 and then wraps. On wrap, sel <= sel+1 (mod 8).
//   - Scan runs in every state, is free-running, and is never cleared by the FSM.
//   - disp_an <= ~(8'b1 << sel), registered: 1-cycle latency from sel.
//   - disp_o <= owner frame digit[sel] in SHOW; 7'h7F in IDLE/BLANK. Registered, same cycle as disp_an.
//   - The frame is sampled live each cycle; no snapshot.
//   FSM states IDLE, SHOW, BLANK:
//   - IDLE: if req!=0, go to SHOW next edge and grant the highest-priority set bit; hold_c <= 0.
//     No blank gap is needed because the display is already blank.
//   - SHOW: hold_c increments and saturates at HOLD_CYC.
//     - Owner drops req -> BLANK (immediate, hold ignored).
//     - Else a higher-priority req while hold_c==HOLD_CYC -> BLANK (preemption).
//     - Lower-priority requests never preempt.
//   - BLANK: grant=0. blank_c counts 0..BLANK_CYC-1.
//     - On the last count, re-arbitrate on current req: highest set -> SHOW with hold_c=0; none -> IDLE.
//     - Requests that drop during BLANK are ignored.
//   Grant:
//   - grant is registered and updates on the same edge as the state change.
//   - Owner frame is shown on disp_o from the first scan digit update after grant rises.
//   Simultaneous events:
//   - Owner drops and a higher-priority request arrives in the same cycle -> BLANK, then arbitrate.
//   - The old owner re-requesting during BLANK competes normally.
//   - Reset mid-SHOW/BLANK returns to IDLE immediately and blanks outputs the following cycle.
//   - Widths: scan_c is $clog2(SCAN_DIV), hold_c is $clog2(HOLD_CYC+1), blank_c is $clog2(BLANK_CYC).
//     All counters are unsigned and do not wrap beyond their terminal count.
// STRUCTURE
//   disp_pkg:
//   - NUM_DIGITS=8, SEG_W=7, SEG_BLANK=7'h7F, AN_OFF=8'hFF.
//   - state enum {IDLE, SHOW, BLANK}.
//   - function digit_of(frame, idx).
//   Sub-module disp_scan:
//   - Holds scan_c, sel, anode decode and the output registers.
//   - Takes frame + blank flag.
//   The arbiter FSM, hold_c and blank_c stay in disp_arbiter.
// TESTING  (bench params SCAN_DIV=4, HOLD_CYC=8, BLANK_CYC=2)
//   - Reset: hold rst_n=0 for 3 cycles -> grant=0, disp_an=FF, disp_o=7F.
//     After release, disp_an walks FE,FD,...,7F every 4 cycles, then wraps to FE.
//   - req=3'b100, frame2 digit k = k -> grant=100 one cycle later.
//     disp_o matches frame2 digit[sel] each slot, 1 cycle behind sel.
//   - Owner 2 holding for 3 cycles, then req=3'b101 -> no preemption until hold_c=8.
//     Then grant=0 for 2 cycles with disp_o=7F, then grant=001.
//   - Owner 0 with req=3'b011: drop req[0] -> BLANK for 2 cycles -> grant=010.
//     Source 1 never preempts while owner 0 holds.
//   - In BLANK, drop all req -> IDLE, grant=0, outputs blank.
//     Then req=3'b001 -> grant=001 after 1 cycle with no blank gap.
//   - Assert rst_n=0 mid-SHOW -> next edge grant=0, state IDLE, scan sel=0.
//     Re-request -> normal grant.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the display arbiter slice.
//   - Display geometry: 8 digits of 7 active-low segments, packed as a
//     56-bit frame with digit k at bits [7k+6:7k] (digit 7 at the MSB).
//   - Blank codes for segments and anodes (all bits high = everything off).
//   - Arbiter state encoding.
//   - digit_of(): extracts one digit from a packed frame.
package disp_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEG_W      = 7;
    localparam int SEL_W      = 3;
    localparam int FRAME_W    = NUM_DIGITS * SEG_W;

    localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } state_t;

    function automatic logic [SEG_W-1:0] digit_of(
        input logic [FRAME_W-1:0] frame,
        input logic [SEL_W-1:0]   idx
    );
        digit_of = frame[SEG_W*int'(idx) +: SEG_W];
    endfunction

endpackage

// File: rtl/disp_scan.sv
// Free-running digit-scan multiplexer for the 8-digit display.
// The scan counter and digit select are never cleared except by reset, so
// the refresh cadence is unaffected by changes of display owner.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   frame       56-bit packed frame to display (sampled live every cycle)
//   blank       1 = drive all segments off instead of the frame
//   disp_an     registered digit enable, active-low, one-hot-zero
//   disp_o      registered segments of the selected digit, active-low
module disp_scan
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 131072
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FRAME_W-1:0]    frame,
    input  logic                  blank,
    output logic [NUM_DIGITS-1:0] disp_an,
    output logic [SEG_W-1:0]      disp_o
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0]         SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

    logic [SW-1:0]         scan_c_q, scan_c_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]      seg_q, seg_d;

    always_comb begin
        scan_c_d = scan_c_q;
        sel_d    = sel_q;
        if (scan_c_q == SCAN_LAST) begin
            scan_c_d = '0;
            // 3-bit select wraps 7 -> 0 on its own.
            sel_d    = sel_q + 1'b1;
        end else begin
            scan_c_d = scan_c_q + 1'b1;
        end
        // Both outputs are built from the current select, so anode and
        // segments always change together, one cycle after sel.
        an_d  = ~(AN_ONE << sel_q);
        seg_d = blank ? SEG_BLANK : digit_of(frame, sel_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_c_q <= '0;
            sel_q    <= '0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_BLANK;
        end else begin
            scan_c_q <= scan_c_d;
            sel_q    <= sel_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign disp_an = an_q;
    assign disp_o  = seg_q;

endmodule

// File: rtl/disp_arbiter.sv
// Shares one 8-digit active-low 7-segment display between three frame
// sources. Fixed priority (req[0] highest), an owner keeps the display for at
// least HOLD_CYC cycles before a higher-priority source may take it, and a
// BLANK_CYC blank gap separates two owners. Dropping the owner's request
// releases the display at once, hold time notwithstanding.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   req[2:0]           request per source, bit 0 = highest priority
//   frame0..frame2     56-bit packed frames, digit k at [7k+6:7k]
//   grant[2:0]         registered one-hot owner, 0 when nobody owns
//   disp_an[7:0]       digit enable, active-low
//   disp_o[6:0]        segments of the selected digit, active-low
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int SCAN_DIV  = 131072,
    parameter int HOLD_CYC  = 2**24,
    parameter int BLANK_CYC = 65536
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            req,
    input  logic [FRAME_W-1:0]    frame0,
    input  logic [FRAME_W-1:0]    frame1,
    input  logic [FRAME_W-1:0]    frame2,
    output logic [2:0]            grant,
    output logic [NUM_DIGITS-1:0] disp_an,
    output logic [SEG_W-1:0]      disp_o
);

    localparam int HW = $clog2(HOLD_CYC + 1);
    // A one-cycle gap still needs a one-bit counter.
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYC);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

    state_t        state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [HW-1:0] hold_c_q, hold_c_d;
    logic [BW-1:0] blank_c_q, blank_c_d;

    logic               owner_req;
    logic               higher_req;
    logic [FRAME_W-1:0] owner_frame;

    function automatic logic [2:0] pick(input logic [2:0] r);
        if (r[0])      pick = 3'b001;
        else if (r[1]) pick = 3'b010;
        else if (r[2]) pick = 3'b100;
        else           pick = 3'b000;
    endfunction

    // With a one-hot grant, grant-1 masks exactly the higher-priority bits.
    // Only meaningful in SHOW, where grant is never zero.
    assign owner_req  = |(req & grant_q);
    assign higher_req = |(req & (grant_q - 3'd1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        hold_c_d  = hold_c_q;
        blank_c_d = blank_c_q;
        case (state_q)
            IDLE: begin
                // Display is already dark, so the first owner starts at once.
                if (|req) begin
                    state_d  = SHOW;
                    grant_d  = pick(req);
                    hold_c_d = '0;
                end
            end
            SHOW: begin
                if (!owner_req || (higher_req && (hold_c_q == HOLD_MAX))) begin
                    state_d   = BLANK;
                    grant_d   = '0;
                    blank_c_d = '0;
                end else if (hold_c_q != HOLD_MAX) begin
                    hold_c_d = hold_c_q + 1'b1;
                end
            end
            BLANK: begin
                if (blank_c_q == BLANK_LAST) begin
                    // Only the request vector at the last gap cycle matters.
                    blank_c_d = '0;
                    if (|req) begin
                        state_d  = SHOW;
                        grant_d  = pick(req);
                        hold_c_d = '0;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else begin
                    blank_c_d = blank_c_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            hold_c_q  <= '0;
            blank_c_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            hold_c_q  <= hold_c_d;
            blank_c_q <= blank_c_d;
        end
    end

    always_comb begin
        case (grant_q)
            3'b001:  owner_frame = frame0;
            3'b010:  owner_frame = frame1;
            3'b100:  owner_frame = frame2;
            default: owner_frame = '1;
        endcase
    end

    disp_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .frame   (owner_frame),
        .blank   (state_q != SHOW),
        .disp_an (disp_an),
        .disp_o  (disp_o)
    );

    assign grant = grant_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter with small parameters. A behavioural model (owner
// index, shown-cycle count, remaining gap cycles, cycles since reset) predicts
// grant/disp_an/disp_o every cycle; directed literal checks pin the model.
module tb_disp_arbiter;

    localparam int SCAN_DIV  = 4;
    localparam int HOLD_CYC  = 8;
    localparam int BLANK_CYC = 2;

    localparam int P_IDLE  = 0;
    localparam int P_SHOW  = 1;
    localparam int P_BLANK = 2;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [55:0] frame0 = '0;
    logic [55:0] frame1 = '0;
    logic [55:0] frame2 = '0;
    logic [2:0]  grant;
    logic [7:0]  disp_an;
    logic [6:0]  disp_o;

    always #5 clk = ~clk;

    disp_arbiter #(
        .SCAN_DIV (SCAN_DIV),
        .HOLD_CYC (HOLD_CYC),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .frame0 (frame0),
        .frame1 (frame1),
        .frame2 (frame2),
        .grant  (grant),
        .disp_an(disp_an),
        .disp_o (disp_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- inputs as seen at each rising edge ----------------
    logic        s_rst_n;
    logic [2:0]  s_req;
    logic [55:0] s_f0, s_f1, s_f2;

    always @(posedge clk) begin
        s_rst_n <= rst_n;
        s_req   <= req;
        s_f0    <= frame0;
        s_f1    <= frame1;
        s_f2    <= frame2;
    end

    // ---------------- behavioural model ----------------
    int         m_phase = P_IDLE;
    int         m_owner = -1;
    int         m_held = 0;
    int         m_blank_left = 0;
    int         m_cnt = 0;
    logic [2:0] exp_grant = 3'b000;
    logic [7:0] exp_an = 8'hFF;
    logic [6:0] exp_o = 7'h7F;
    bit         seen_reset = 0;

    function automatic int lowest_req(input logic [2:0] r);
        for (int i = 0; i < 3; i++)
            if (r[i]) return i;
        return -1;
    endfunction

    function automatic logic [6:0] digit(input logic [55:0] f, input int k);
        logic [55:0] sh;
        sh = (f >> (7 * k)) & 56'h7F;
        return sh[6:0];
    endfunction

    task automatic model_step();
        int sel;
        int lo;
        logic [55:0] f;
        if (s_rst_n !== 1'b1) begin
            m_phase = P_IDLE;
            m_owner = -1;
            m_held = 0;
            m_blank_left = 0;
            m_cnt = 0;
            exp_an = 8'hFF;
            exp_o = 7'h7F;
        end else begin
            sel = (m_cnt / SCAN_DIV) % 8;
            exp_an = ~(8'd1 << sel);
            f = (m_owner == 0) ? s_f0 : (m_owner == 1) ? s_f1 : s_f2;
            exp_o = (m_phase == P_SHOW) ? digit(f, sel) : 7'h7F;
            m_cnt++;
            lo = lowest_req(s_req);
            case (m_phase)
                P_IDLE: begin
                    if (lo >= 0) begin
                        m_phase = P_SHOW;
                        m_owner = lo;
                        m_held = 0;
                    end
                end
                P_SHOW: begin
                    if (!s_req[m_owner] || (m_held == HOLD_CYC && lo < m_owner)) begin
                        m_phase = P_BLANK;
                        m_owner = -1;
                        m_blank_left = BLANK_CYC;
                    end else if (m_held < HOLD_CYC) begin
                        m_held++;
                    end
                end
                default: begin
                    m_blank_left--;
                    if (m_blank_left == 0) begin
                        if (lo >= 0) begin
                            m_phase = P_SHOW;
                            m_owner = lo;
                            m_held = 0;
                        end else begin
                            m_phase = P_IDLE;
                        end
                    end
                end
            endcase
        end
        exp_grant = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (s_rst_n === 1'b0) seen_reset = 1;
        if (seen_reset) begin
            model_step();
            check("model_grant", {29'd0, grant}, {29'd0, exp_grant});
            check("model_disp_an", {24'd0, disp_an}, {24'd0, exp_an});
            check("model_disp_o", {25'd0, disp_o}, {25'd0, exp_o});
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_grant(input logic [2:0] want, input int max_cyc, input string name,
                              output int n);
        n = 0;
        while (grant !== want && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(name, {29'd0, grant}, {29'd0, want});
    endtask

    function automatic logic [55:0] rand_frame();
        return 56'({$urandom(), $urandom()});
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n;
        frame0 = rand_frame();
        frame1 = rand_frame();
        for (int k = 0; k < 8; k++) frame2[7*k +: 7] = 7'(k);

        // Reset held for 3 cycles.
        rst_n = 1'b0;
        req = 3'b000;
        repeat (3) @(negedge clk);
        check("reset_grant", {29'd0, grant}, 32'h0);
        check("reset_an", {24'd0, disp_an}, 32'hFF);
        check("reset_o", {25'd0, disp_o}, 32'h7F);

        // Scan walk after release.
        rst_n = 1'b1;
        @(negedge clk);
        check("scan_first_FE", {24'd0, disp_an}, 32'hFE);
        repeat (4) @(negedge clk);
        check("scan_second_FD", {24'd0, disp_an}, 32'hFD);
        repeat (30) @(negedge clk);

        // Source 2 takes an idle display.
        req = 3'b100;
        @(negedge clk);
        check("grant_src2", {29'd0, grant}, 32'h4);
        repeat (2) @(negedge clk);

        // Higher-priority request waits for the hold time.
        req = 3'b101;
        @(negedge clk);
        check("no_early_preempt", {29'd0, grant}, 32'h4);
        wait_grant(3'b000, 20, "preempt_to_blank", n);
        check("preempt_delay", n, 32'd6);
        @(negedge clk);
        check("blank_gap_grant", {29'd0, grant}, 32'h0);
        check("blank_gap_o", {25'd0, disp_o}, 32'h7F);
        @(negedge clk);
        check("grant_src0", {29'd0, grant}, 32'h1);

        // Lower priority never preempts; owner drop releases immediately.
        req = 3'b011;
        repeat (12) @(negedge clk);
        check("src1_no_preempt", {29'd0, grant}, 32'h1);
        req = 3'b010;
        @(negedge clk);
        check("drop_blank1", {29'd0, grant}, 32'h0);
        @(negedge clk);
        check("drop_blank2", {29'd0, grant}, 32'h0);
        @(negedge clk);
        check("grant_src1", {29'd0, grant}, 32'h2);

        // Everything drops: gap then idle, then immediate grant.
        req = 3'b000;
        repeat (4) @(negedge clk);
        check("idle_grant", {29'd0, grant}, 32'h0);
        check("idle_o", {25'd0, disp_o}, 32'h7F);
        req = 3'b001;
        @(negedge clk);
        check("idle_to_src0", {29'd0, grant}, 32'h1);

        // Reset in the middle of SHOW.
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_grant", {29'd0, grant}, 32'h0);
        check("midreset_an", {24'd0, disp_an}, 32'hFF);
        check("midreset_o", {25'd0, disp_o}, 32'h7F);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerequest_grant", {29'd0, grant}, 32'h1);
        check("rerequest_an", {24'd0, disp_an}, 32'hFE);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 30) == 0) frame0 = rand_frame();
            if ($urandom_range(0, 30) == 0) frame1 = rand_frame();
            if ($urandom_range(0, 30) == 0) frame2 = rand_frame();
            rst_n = ($urandom_range(0, 500) == 0) ? 1'b0 : 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
